// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// Module  : dmem_pkg
// Purpose : Shared funct3 encodings, FSM states and access-fault check for lsu_dmem.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // Unsigned sizes exist only for loads, so BU/HU fault when used by a store.
   function automatic logic access_fault(input logic [2:0] funct3,
                                         input logic       wren,
                                         input logic [1:0] addr_lo);
      logic flt;
      case (funct3)
         F3_B:    flt = 1'b0;
         F3_H:    flt = addr_lo[0];
         F3_W:    flt = (addr_lo != 2'b00);
         F3_BU:   flt = wren;
         F3_HU:   flt = wren | addr_lo[0];
         default: flt = 1'b1;
      endcase
      return flt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
//------------------------------------------------------------------------------
// Module  : dmem_lane_align
// Purpose : Byte-lane enables, store-data replication, load extension and fault flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic        wren,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] rd_word,
   output logic [3:0]  byte_en,
   output logic [31:0] wr_data,
   output logic [31:0] ld_data,
   output logic        fault
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   assign fault = access_fault(funct3, wren, addr_lo);

   // Data is replicated across lanes; byte_en alone picks which lanes land.
   always_comb begin
      byte_en = 4'b0000;
      wr_data = st_data;
      case (funct3)
         F3_B: begin
            byte_en = 4'b0001 << addr_lo;
            wr_data = {4{st_data[7:0]}};
         end
         F3_H: begin
            byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{st_data[15:0]}};
         end
         F3_W: begin
            byte_en = 4'b1111;
            wr_data = st_data;
         end
         default: begin
            byte_en = 4'b0000;
            wr_data = st_data;
         end
      endcase
   end

   always_comb begin
      case (addr_lo)
         2'd0:    sel_byte = rd_word[7:0];
         2'd1:    sel_byte = rd_word[15:8];
         2'd2:    sel_byte = rd_word[23:16];
         default: sel_byte = rd_word[31:24];
      endcase
      sel_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
   end

   always_comb begin
      ld_data = 32'd0;
      case (funct3)
         F3_B:    ld_data = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   ld_data = {24'd0, sel_byte};
         F3_H:    ld_data = {{16{sel_half[15]}}, sel_half};
         F3_HU:   ld_data = {16'd0, sel_half};
         F3_W:    ld_data = rd_word;
         default: ld_data = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/lsu_dmem.sv
//------------------------------------------------------------------------------
// Module  : lsu_dmem
// Purpose : LSU data memory with byte/half/word access, 1-cycle loads and clear sweep.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_dmem
   import dmem_pkg::*;
#(
   parameter int    DEPTH_WORDS    = 512,
   parameter bit    CLEAR_ON_RESET = 1'b1,
   parameter string INIT_FILE      = ""
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_wren,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_st_data,
   output logic        o_ready,
   output logic        o_busy,
   output logic        o_ld_valid,
   output logic [31:0] o_ld_data,
   output logic        o_fault
);

   localparam int              WIDX_W   = $clog2(DEPTH_WORDS);
   localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(DEPTH_WORDS - 1);

   logic [31:0]       mem [0:DEPTH_WORDS-1];
   state_t            state;
   logic [WIDX_W-1:0] clr_idx;
   logic [WIDX_W-1:0] req_idx;
   logic [WIDX_W-1:0] mem_idx;
   logic [31:0]       rd_word;
   logic [3:0]        byte_en;
   logic [31:0]       wr_data;
   logic [31:0]       ext_data;
   logic              req_fault;
   logic              accept;
   logic              clearing;
   logic [3:0]        mem_we;
   logic [31:0]       mem_wdata;
   logic              unused_addr;

   assign req_idx     = i_addr[WIDX_W+1:2];
   assign unused_addr = ^i_addr[31:WIDX_W+2];

   assign o_ready  = (state == ST_READY) && !i_reset;
   assign o_busy   = (state == ST_CLEAR);
   assign accept   = o_ready && i_req;
   assign clearing = (state == ST_CLEAR) && !i_reset;
   assign rd_word  = mem[req_idx];

   dmem_lane_align u_align (
      .funct3  (i_funct3),
      .wren    (i_wren),
      .addr_lo (i_addr[1:0]),
      .st_data (i_st_data),
      .rd_word (rd_word),
      .byte_en (byte_en),
      .wr_data (wr_data),
      .ld_data (ext_data),
      .fault   (req_fault)
   );

   // The clear sweep and stores share the single write port.
   always_comb begin
      mem_idx   = req_idx;
      mem_wdata = wr_data;
      mem_we    = 4'b0000;
      if (clearing) begin
         mem_idx   = clr_idx;
         mem_wdata = 32'd0;
         mem_we    = 4'b1111;
      end else if (accept && i_wren && !req_fault) begin
         mem_we = byte_en;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int lane = 0; lane < 4; lane++) begin
         if (mem_we[lane]) begin
            mem[mem_idx][8*lane +: 8] <= mem_wdata[8*lane +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clr_idx    <= '0;
         o_ld_valid <= 1'b0;
         o_ld_data  <= 32'd0;
         o_fault    <= 1'b0;
      end else begin
         o_ld_valid <= 1'b0;
         o_fault    <= 1'b0;
         case (state)
            ST_CLEAR: begin
               clr_idx <= clr_idx + WIDX_W'(1);
               if (clr_idx == LAST_IDX) begin
                  state <= ST_READY;
               end
            end
            ST_READY: begin
               if (i_req) begin
                  if (req_fault) begin
                     o_fault <= 1'b1;
                  end else if (!i_wren) begin
                     o_ld_valid <= 1'b1;
                     o_ld_data  <= ext_data;
                  end
               end
            end
            default: state <= ST_READY;
         endcase
      end
   end

endmodule

`default_nettype wire
